mips_regfile_sb: RTL and testbench

- Parametrised register file for the MIPS pipeline decode stage. Successor to the fixed 32x32, 2-read, negedge-write register file.
- Adds N read ports, a same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits between the decode-stage operand fetch and writeback. Decode reads operands and busy flags; issue marks destinations pending; writeback retires them.

---
 rtl/mips_regfile_sb.sv | 121 ++++++++++++
 tb/tb_mips_regfile_sb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_sb.sv
// Decode-stage register file: NUM_RD combinational read ports with write bypass, plus busy scoreboard.
// Latency: reads 0 cycles (bypassed same-cycle write), writes/scoreboard updates take effect at next posedge.
// Backpressure: none; rd_busy/sb_full tell the caller when to stall. Option macro: MIPS_REGFILE_PARITY_EN.
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     sb_full
`ifdef MIPS_REGFILE_PARITY_EN
  ,
  input  logic                     perr_inject,
  output logic [NUM_RD-1:0]        rd_perr
`endif
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam bit              HAS_ZERO = (ZERO_REG != 0);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH - ZERO_REG);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              rise;
  logic              fall;

  // A write to the hardwired zero register is discarded everywhere.
  assign wr_ok = wr_en && !(HAS_ZERO && (wr_addr == '0));

  // Register storage; async reset zeroes every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next busy vector: retire first, then issue, so a new producer wins on the same index.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (sb_set) begin
      busy_nxt[sb_addr] = 1'b1;
    end
    if (HAS_ZERO) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // Only one index can rise (sb_addr) and one can fall (wr_addr) per cycle, so the
  // count moves by at most one and simultaneous events on different indices cancel.
  assign rise = |(busy_nxt & ~busy);
  assign fall = |(busy & ~busy_nxt);

  // Busy bits and their population count, kept in lock-step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      case ({rise, fall})
        2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
        2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  assign sb_full = (busy_cnt == FULL_CNT);

`ifdef MIPS_REGFILE_PARITY_EN
  logic [DEPTH-1:0] par;

  // Even parity of the data actually written; perr_inject flips it for fault testing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= '0;
    end else if (wr_ok) begin
      par[wr_addr] <= (^wr_data) ^ perr_inject;
    end
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic              zero;

    assign a    = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit  = wr_ok && (wr_addr == a);
    assign zero = HAS_ZERO && (a == '0);

    assign rd_data[i*DATA_W +: DATA_W] = zero ? '0 : (hit ? wr_data : mem[a]);
    // A retiring write is bypassed, so its consumer does not need to stall.
    assign rd_busy[i] = busy[a] & ~(wr_en && (wr_addr == a));
`ifdef MIPS_REGFILE_PARITY_EN
    assign rd_perr[i] = (zero || hit) ? 1'b0 : ((^mem[a]) ^ par[a]);
`endif
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Scoreboard bench for mips_regfile_sb: directed plan items followed by random traffic.
// Stimulus pushes expected outputs from an array-based reference model; a monitor compares at negedge.
// Works with or without MIPS_REGFILE_PARITY_EN defined.
module tb_mips_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_busy;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           sb_set;
  logic [AW-1:0]  sb_addr;
  logic [AW:0]    busy_cnt;
  logic           sb_full;
`ifdef MIPS_REGFILE_PARITY_EN
  logic           perr_inject;
  logic [NR-1:0]  rd_perr;
`endif

  always #5 clk = ~clk;

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_cnt(busy_cnt), .sb_full(sb_full)
`ifdef MIPS_REGFILE_PARITY_EN
    , .perr_inject(perr_inject), .rd_perr(rd_perr)
`endif
  );

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    busy;
    logic [AW:0]      cnt;
    logic             full;
    logic [NR-1:0]    perr;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: architectural contents, pending producers, corrupted-parity flags.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy[DEPTH];
  bit            m_bad [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k] = '0;
      m_busy[k] = 1'b0;
      m_bad[k] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; sb_set = 1'b0; sb_addr = '0; rd_addr = '0;
`ifdef MIPS_REGFILE_PARITY_EN
    perr_inject = 1'b0;
`endif
  endtask

  // Drive one cycle of inputs, predict outputs, then advance the model across the edge.
  task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit ss, input int sa, input int ra0, input int ra1, input bit inj);
    exp_t e;
    int   a;
    int   n;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    sb_set = ss; sb_addr = AW'(sa);
    rd_addr = {AW'(ra1), AW'(ra0)};
`ifdef MIPS_REGFILE_PARITY_EN
    perr_inject = inj;
`endif
    e = '0;
    for (int i = 0; i < NR; i++) begin
      a = (i == 0) ? ra0 : ra1;
      if (a == 0) e.data[i*DW +: DW] = '0;
      else if (we && wa == a) e.data[i*DW +: DW] = wd;
      else e.data[i*DW +: DW] = m_mem[a];
      e.busy[i] = m_busy[a] && !(we && wa == a);
      e.perr[i] = (a != 0) && !(we && wa == a) && m_bad[a];
    end
    n = 0;
    for (int k = 0; k < DEPTH; k++) if (m_busy[k]) n++;
    e.cnt = (AW + 1)'(n);
    e.full = (n == DEPTH - 1);
    q.push_back(e);
    if (we && wa != 0) begin
      m_mem[wa] = wd;
      m_bad[wa] = inj;
    end
    if (we) m_busy[wa] = 1'b0;
    if (ss && sa != 0) m_busy[sa] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: consume one expectation per presented cycle and compare.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < NR; i++) begin
          check($sformatf("rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(e.data[i*DW +: DW]));
        end
        check("rd_busy", 64'(rd_busy), 64'(e.busy));
        check("busy_cnt", 64'(busy_cnt), 64'(e.cnt));
        check("sb_full", 64'(sb_full), 64'(e.full));
`ifdef MIPS_REGFILE_PARITY_EN
        check("rd_perr", 64'(rd_perr), 64'(e.perr));
`endif
      end
    end
  end

  initial begin
    int wa;
    int sa;
    idle();
    model_reset();
    rst = 1'b0;
    #3;
    check("reset_busy_cnt", 64'(busy_cnt), 64'd0);
    check("reset_sb_full", 64'(sb_full), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Plan 1: every register reads zero and idle after reset.
    for (int k = 0; k < DEPTH; k += 2) step(0, 0, '0, 0, 0, k, k + 1, 0);

    // Plan 2: same-cycle bypass, then stored value.
    step(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 0);
    step(0, 0, '0, 0, 0, 5, 0, 0);

    // Plan 3: r0 ignores writes and issue.
    step(1, 0, 32'h1234, 1, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 5, 0);

    // Plan 4: issue r7, then retire and re-issue r7 in the same cycle.
    step(0, 0, '0, 1, 7, 7, 0, 0);
    step(0, 0, '0, 0, 0, 7, 7, 0);
    step(1, 7, 32'hA5A5_0007, 1, 7, 7, 0, 0);
    step(0, 0, '0, 0, 0, 7, 5, 0);
    // Retiring an idle register and re-issuing a busy one leave the count alone.
    step(1, 9, 32'h9, 1, 7, 9, 7, 0);

    // Plan 5: fill the scoreboard, then reset between edges.
    for (int k = 1; k < DEPTH; k++) step(0, 0, '0, 1, k, k, 7, 0);
    step(0, 0, '0, 0, 0, 31, 1, 0);
    idle();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy_cnt", 64'(busy_cnt), 64'd0);
    check("midrst_sb_full", 64'(sb_full), 64'd0);
    check("midrst_rd_busy", 64'(rd_busy), 64'd0);
    rd_addr = {AW'(7), AW'(5)};
    #1;
    check("midrst_rd_data", 64'(rd_data), 64'd0);
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    step(0, 0, '0, 0, 0, 5, 7, 0);

    // Plan 6: parity injection, then clean rewrite.
    step(1, 3, 32'h0F0F0F0F, 0, 0, 3, 0, 1);
    step(0, 0, '0, 0, 0, 3, 3, 0);
    step(1, 3, 32'h0F0F0F0F, 0, 0, 4, 3, 0);
    step(0, 0, '0, 0, 0, 3, 4, 0);

    // Random traffic, biased toward a few registers so hazards collide often.
    for (int n = 0; n < 1500; n++) begin
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      step(bit'($urandom_range(0, 1)), wa, $urandom, bit'($urandom_range(0, 1)), sa,
           ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, 7)),
           int'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
    end

    idle();
    for (int k = 0; k < 100 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
